// File: rtl/otp_auth_ctrl.sv
// -----------------------------------------------------------------------------
// otp_auth_ctrl
//
// One-time-password entry controller. A generated code is captured from
// otp_in, the user keys digits one at a time, and the completed entry is
// compared against the captured code. A wrong entry counts an attempt; too
// many attempts lock the session. The session also expires a fixed number of
// cycles after the code was captured. UNLOCKED, EXPIRED and LOCKED are shown
// for a fixed hold time before the controller returns to IDLE.
//
// Configuration macro:
//   OTP_AUTH_BACKSPACE_EN  defined   -> digit_del removes the last digit
//                          undefined -> digit_del is ignored (port kept)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   otp_in       in   generated code, first-entered digit in the MSBs
//   otp_valid    in   otp_in strobe (honoured in WAIT_OTP only)
//   digit_in     in   user digit
//   digit_valid  in   one digit per high cycle (honoured in ENTRY only)
//   digit_del    in   delete last digit (backspace build only)
//   unlock       out  high in UNLOCKED
//   expired      out  high in EXPIRED
//   locked       out  high in LOCKED
//   attempts     out  wrong entries this session
//   entry_count  out  digits currently held
//   entry_code   out  entered digits, same packing as otp_in, empty slots zero
//   otp_q        out  captured code
//   state        out  IDLE=0 WAIT_OTP=1 ENTRY=2 CHECK=3 UNLOCKED=4
//                     EXPIRED=5 LOCKED=6
// -----------------------------------------------------------------------------
module otp_auth_ctrl #(
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter int EXPIRE_CYCLES = 1500,
    parameter int HOLD_CYCLES   = 250,
    parameter int MAX_ATTEMPTS  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIGITS*DIGIT_W-1:0] otp_in,
    input  logic                      otp_valid,
    input  logic [DIGIT_W-1:0]        digit_in,
    input  logic                      digit_valid,
    input  logic                      digit_del,
    output logic                      unlock,
    output logic                      expired,
    output logic                      locked,
    output logic [3:0]                attempts,
    output logic [3:0]                entry_count,
    output logic [DIGITS*DIGIT_W-1:0] entry_code,
    output logic [DIGITS*DIGIT_W-1:0] otp_q,
    output logic [2:0]                state
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int SESS_W = $clog2(EXPIRE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    localparam logic [SESS_W-1:0] SESS_LAST  = SESS_W'(EXPIRE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        COUNT_LAST = 4'(DIGITS - 1);
    localparam logic [3:0]        ATT_LIMIT  = 4'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_OTP = 3'd1,
        S_ENTRY    = 3'd2,
        S_CHECK    = 3'd3,
        S_UNLOCKED = 3'd4,
        S_EXPIRED  = 3'd5,
        S_LOCKED   = 3'd6
    } state_t;

    state_t              state_q, state_n;
    logic [CODE_W-1:0]   otp_n, entry_n;
    logic [3:0]          count_n, attempts_n;
    logic [SESS_W-1:0]   sess_q, sess_n;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic                del_req;

`ifdef OTP_AUTH_BACKSPACE_EN
    assign del_req = digit_del;
`else
    // Backspace disabled: the port stays for pin compatibility but is inert.
    logic unused_digit_del;
    assign unused_digit_del = digit_del;
    assign del_req          = 1'b0;
`endif

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Next-state and next-datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every comb output is given a default first so no path through
        // the case statement can leave a value unassigned and infer a latch.
        state_n    = state_q;
        otp_n      = otp_q;
        entry_n    = entry_code;
        count_n    = entry_count;
        attempts_n = attempts;
        sess_n     = sess_q;
        hold_n     = hold_q;

        case (state_q)
            S_IDLE: begin
                otp_n      = '0;
                entry_n    = '0;
                count_n    = '0;
                attempts_n = '0;
                sess_n     = '0;
                hold_n     = '0;
                state_n    = S_WAIT_OTP;
            end

            S_WAIT_OTP: begin
                if (otp_valid) begin
                    otp_n   = otp_in;
                    sess_n  = '0;
                    state_n = S_ENTRY;
                end
            end

            S_ENTRY: begin
                sess_n = sess_q + 1'b1;
                // ">=" rather than "==": a wrong entry checked on the last
                // session cycle returns here with the timer already past the
                // limit, and that session must still expire at once.
                if (sess_q >= SESS_LAST) begin
                    hold_n  = '0;
                    state_n = S_EXPIRED;
                end else if (digit_valid) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (entry_count == 4'(i))
                            entry_n[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
                    end
                    count_n = entry_count + 4'd1;
                    if (entry_count == COUNT_LAST)
                        state_n = S_CHECK;
                end else if (del_req && entry_count != 4'd0) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (entry_count == 4'(i + 1))
                            entry_n[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = '0;
                    end
                    count_n = entry_count - 4'd1;
                end
            end

            S_CHECK: begin
                sess_n = sess_q + 1'b1;
                hold_n = '0;
                if (entry_code == otp_q) begin
                    state_n = S_UNLOCKED;
                end else begin
                    attempts_n = attempts + 4'd1;
                    if (attempts_n == ATT_LIMIT) begin
                        state_n = S_LOCKED;
                    end else begin
                        entry_n = '0;
                        count_n = '0;
                        state_n = S_ENTRY;
                    end
                end
            end

            S_UNLOCKED, S_EXPIRED, S_LOCKED: begin
                if (hold_q == HOLD_LAST)
                    state_n = S_IDLE;
                else
                    hold_n = hold_q + 1'b1;
            end

            default: state_n = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: every register here is plain flop state (no RAM), so all of it is
    // cleared by reset; the flags are registered from state_n so they line up
    // exactly with the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            otp_q       <= '0;
            entry_code  <= '0;
            entry_count <= '0;
            attempts    <= '0;
            sess_q      <= '0;
            hold_q      <= '0;
            unlock      <= 1'b0;
            expired     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_n;
            otp_q       <= otp_n;
            entry_code  <= entry_n;
            entry_count <= count_n;
            attempts    <= attempts_n;
            sess_q      <= sess_n;
            hold_q      <= hold_n;
            unlock      <= (state_n == S_UNLOCKED);
            expired     <= (state_n == S_EXPIRED);
            locked      <= (state_n == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otp_auth_ctrl
//
// Self-checking bench for otp_auth_ctrl with DIGITS=4, EXPIRE_CYCLES=100,
// HOLD_CYCLES=10, MAX_ATTEMPTS=3. A session-level model (captured code, queue
// of entered digits, session age, hold time served) is stepped on every rising
// edge and compared against all DUT outputs on every falling edge. Directed
// scenarios add hand-computed literal expectations; two randomized phases then
// exercise the model comparison. Honours OTP_AUTH_BACKSPACE_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_otp_auth_ctrl;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int EXPIRE  = 100;
    localparam int HOLD    = 10;
    localparam int MAXA    = 3;

    localparam int ST_IDLE = 0, ST_WAIT = 1, ST_ENTRY = 2, ST_CHECK = 3;
    localparam int ST_UNLOCKED = 4, ST_EXPIRED = 5, ST_LOCKED = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] otp_in;
    logic        otp_valid;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        digit_del;
    logic        unlock, expired, locked;
    logic [3:0]  attempts, entry_count;
    logic [15:0] entry_code, otp_q;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    otp_auth_ctrl #(
        .DIGITS       (DIGITS),
        .DIGIT_W      (DIGIT_W),
        .EXPIRE_CYCLES(EXPIRE),
        .HOLD_CYCLES  (HOLD),
        .MAX_ATTEMPTS (MAXA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .otp_in     (otp_in),
        .otp_valid  (otp_valid),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .digit_del  (digit_del),
        .unlock     (unlock),
        .expired    (expired),
        .locked     (locked),
        .attempts   (attempts),
        .entry_count(entry_count),
        .entry_code (entry_code),
        .otp_q      (otp_q),
        .state      (state)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    int          m_state;
    logic [15:0] m_otp;
    logic [3:0]  m_digits[$];
    int          m_att;
    int          m_age;     // cycles spent in the session since capture
    int          m_served;  // cycles served in the current result display

    function automatic logic [15:0] m_entry_code();
        logic [15:0] v = '0;
        for (int i = 0; i < m_digits.size(); i++)
            v = v | (16'(m_digits[i]) << ((DIGITS - 1 - i) * DIGIT_W));
        return v;
    endfunction

    task automatic model_clear();
        m_otp = '0;
        m_digits.delete();
        m_att = 0;
        m_age = 0;
        m_served = 0;
    endtask

    task automatic model_step();
        bit run_out;
        if (reset) begin
            model_clear();
            m_state = ST_IDLE;
            return;
        end
        case (m_state)
            ST_IDLE: begin
                model_clear();
                m_state = ST_WAIT;
            end
            ST_WAIT: if (otp_valid) begin
                m_otp   = otp_in;
                m_age   = 0;
                m_state = ST_ENTRY;
            end
            ST_ENTRY: begin
                run_out = (m_age >= EXPIRE - 1);
                m_age++;
                if (run_out) begin
                    m_served = 0;
                    m_state  = ST_EXPIRED;
                end else if (digit_valid) begin
                    m_digits.push_back(digit_in);
                    if (m_digits.size() == DIGITS) m_state = ST_CHECK;
                end
`ifdef OTP_AUTH_BACKSPACE_EN
                else if (digit_del && m_digits.size() > 0) begin
                    void'(m_digits.pop_back());
                end
`endif
            end
            ST_CHECK: begin
                m_age++;
                m_served = 0;
                if (m_entry_code() == m_otp) begin
                    m_state = ST_UNLOCKED;
                end else begin
                    m_att++;
                    if (m_att == MAXA) begin
                        m_state = ST_LOCKED;
                    end else begin
                        m_digits.delete();
                        m_state = ST_ENTRY;
                    end
                end
            end
            default: begin
                m_served++;
                if (m_served == HOLD) m_state = ST_IDLE;
            end
        endcase
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        check("state",       64'(state),       64'(m_state));
        check("unlock",      64'(unlock),      64'(m_state == ST_UNLOCKED));
        check("expired",     64'(expired),     64'(m_state == ST_EXPIRED));
        check("locked",      64'(locked),      64'(m_state == ST_LOCKED));
        check("attempts",    64'(attempts),    64'(m_att));
        check("entry_count", 64'(entry_count), 64'(m_digits.size()));
        check("entry_code",  64'(entry_code),  64'(m_entry_code()));
        check("otp_q",       64'(otp_q),       64'(m_otp));
    end

    // ------------------------------------------------------------ drive tasks
    task automatic quiet();
        otp_valid   = 1'b0;
        digit_valid = 1'b0;
        digit_del   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 64'(state), 64'(s));
    endtask

    task automatic send_otp(input logic [15:0] code);
        wait_state(ST_WAIT, 20, "wait_otp");
        otp_in    = code;
        otp_valid = 1'b1;
        @(negedge clk);
        otp_valid = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic send_del();
        digit_del = 1'b1;
        @(negedge clk);
        digit_del = 1'b0;
    endtask

    task automatic count_high(input string tag, input int which,
                              input int expect_n);
        int n = 0;
        while (n < 50 && ((which == 0 && unlock) || (which == 1 && expired) ||
                          (which == 2 && locked))) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_hold_len"}, 64'(n), 64'(expect_n));
        check({tag, "_then_idle"}, 64'(state), 64'(ST_IDLE));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        reset = 1'b1;
        otp_in = '0;
        digit_in = '0;
        quiet();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_state", 64'(state), 64'(ST_IDLE));
        check("rst_flags", 64'({unlock, expired, locked}), 64'(0));
        check("rst_otp_q", 64'(otp_q), 64'(0));

        // Correct code unlocks for exactly HOLD cycles
        send_otp(16'h1234);
        check("cap_state", 64'(state), 64'(ST_ENTRY));
        check("cap_otp_q", 64'(otp_q), 64'h1234);
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
        check("ok_check", 64'(state), 64'(ST_CHECK));
        check("ok_code", 64'(entry_code), 64'h1234);
        @(negedge clk);
        check("ok_unlock", 64'(unlock), 64'(1));
        count_high("ok", 0, HOLD);

        // Three wrong entries lock the session
        send_otp(16'h1234);
        for (int k = 1; k <= MAXA; k++) begin
            repeat (DIGITS) send_digit(4'd1);
            check("bad_check", 64'(state), 64'(ST_CHECK));
            @(negedge clk);
            check("bad_attempts", 64'(attempts), 64'(k));
            if (k < MAXA) begin
                check("bad_retry_state", 64'(state), 64'(ST_ENTRY));
                check("bad_retry_count", 64'(entry_count), 64'(0));
            end
        end
        check("bad_locked", 64'(locked), 64'(1));
        count_high("lock", 2, HOLD);

        // Idle session expires after EXPIRE cycles in entry
        send_otp(16'h5678);
        n = 0;
        send_digit(4'd5); n++;
        send_digit(4'd6); n++;
        while (int'(state) == ST_ENTRY && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("exp_entry_len", 64'(n), 64'(EXPIRE));
        check("exp_flag", 64'(expired), 64'(1));
        check("exp_count_kept", 64'(entry_count), 64'(2));
        count_high("exp", 1, HOLD);

        // Digit on the exact expiry cycle is dropped
        send_otp(16'h4321);
        repeat (EXPIRE - 1) @(negedge clk);
        check("edge_still_entry", 64'(state), 64'(ST_ENTRY));
        send_digit(4'd4);
        check("edge_expired", 64'(state), 64'(ST_EXPIRED));
        check("edge_not_stored", 64'(entry_count), 64'(0));
        wait_state(ST_IDLE, 30, "edge_idle");

        // Backspace sequence
        send_otp(16'h1234);
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd9);
        send_del();
        send_digit(4'd3); send_digit(4'd4);
        @(negedge clk);
`ifdef OTP_AUTH_BACKSPACE_EN
        check("bs_unlock", 64'(unlock), 64'(1));
`else
        check("nobs_attempts", 64'(attempts), 64'(1));
        check("nobs_state", 64'(state), 64'(ST_ENTRY));
`endif
        do_reset();

        // Reset during the fifth unlocked cycle, with competing inputs
        send_otp(16'h1234);
        send_digit(4'd1); send_digit(4'd2); send_digit(4'd3); send_digit(4'd4);
        @(negedge clk);
        check("mid_unlock", 64'(unlock), 64'(1));
        repeat (4) @(negedge clk);
        reset = 1'b1; otp_valid = 1'b1; digit_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; quiet();
        check("mid_rst_state", 64'(state), 64'(ST_IDLE));
        check("mid_rst_outs", 64'({unlock, expired, locked, attempts, entry_count,
                                   entry_code, otp_q}), 64'(0));

        // Randomized phases: busy keypad, then sparse keypad to reach expiry
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 8000; c++) begin
                reset       = ($urandom_range(0, 999) == 0);
                otp_valid   = ($urandom_range(0, 3) == 0);
                otp_in      = ($urandom_range(0, 1) == 0) ? 16'h1234 : 16'($urandom);
                digit_valid = (phase == 0) ? ($urandom_range(0, 2) != 0)
                                           : ($urandom_range(0, 39) == 0);
                digit_del   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0 && m_digits.size() < DIGITS)
                    digit_in = 4'(m_otp >> ((DIGITS - 1 - m_digits.size()) * DIGIT_W));
                else
                    digit_in = 4'($urandom);
                @(negedge clk);
            end
        end
        reset = 1'b0;
        quiet();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
